// File: rtl/down_count_timer.sv
// Loadable n-bit down-counter timer with run/done handshake and optional auto-reload.
// The counter saturates at zero; it never wraps to all-ones.
module down_count_timer #(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         ld,
    input  logic [n-1:0] D,
    input  logic         start,
    input  logic         pause,
    input  logic         auto,
    output logic [n-1:0] count,
    output logic         busy,
    output logic         done,
    output logic         zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [n-1:0] ONE = {{(n-1){1'b0}}, 1'b1};

    state_t       r_state;
    logic [n-1:0] r_count;
    logic [n-1:0] r_reload;
    logic         r_busy;
    logic         r_done;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_reload <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ld) begin
                        r_reload <= D;
                        r_count  <= D;
                    end else if (start) begin
                        if (r_count != '0) begin
                            r_state <= S_RUN;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end

                S_RUN: begin
                    if (ld) begin
                        r_reload <= D;
                        r_count  <= D;
                        if (D == '0) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end else if (!pause) begin
                        // Zero in RUN is unreachable, but finish rather than wrap if it ever occurs.
                        if (r_count <= ONE) begin
                            r_count <= '0;
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_count <= r_count - ONE;
                        end
                    end
                end

                S_DONE: begin
                    r_done <= 1'b0;
                    if (ld) begin
                        r_reload <= D;
                        r_count  <= D;
                        r_state  <= S_IDLE;
                    end else if (auto && (r_reload != '0)) begin
                        r_count <= r_reload;
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                    end else begin
                        r_count <= '0;
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_count <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign count = r_count;
    assign busy  = r_busy;
    assign done  = r_done;
    assign zero  = (r_count == '0);

endmodule
